bcd_counter_0_19: RTL and testbench
===================================

// Module: bcd_counter_0_19
// PURPOSE
//  Seconds-style 0..19 counter for the two-digit display path. It divides clk down to a count
//  tick, holds the count as ones/tens BCD and encodes both digits to 7-segment patterns.
//  It drives disp0 (ones) and disp1 (tens) straight into the downstream scan/multiplex stage.
//  Run/pause and clear come from raw push-button levels, synchronised inside the block.
// PARAMETERS
//  CLK_HZ      50_000_000  clk frequency in Hz
//  TICK_HZ     1           count rate in Hz; DIV = CLK_HZ/TICK_HZ; DIV must be >= 2 (elaboration check)
//  BLANK_TENS  1           1: tens digit blank (7'b0) when tens==0; 0: shows '0'
// PORTS
//  clk         in   1  system clock; single clock domain
//  rst_n       in   1  reset, synchronous, active-low
//  run_btn     in   1  raw async level; each rising edge toggles running
//  clr_btn     in   1  raw async level; each rising edge clears count and prescaler
//  up_dn       in   1  1 = count up, 0 = count down; sampled at each tick
//  disp0       out  7  ones-digit segments {g,f,e,d,c,b,a}, active-high, bit0 = a
//  disp1       out  7  tens-digit segments, same encoding
//  count_val   out  5  current count, binary, 0..19
//  running     out  1  1 = counting enabled
//  wrap_pulse  out  1  one-cycle pulse on 19->0 (up) or 0->19 (down)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk): count 0, prescaler 0, running 0, wrap_pulse 0,
//   disp0 = 7'b0111111 ('0'), disp1 = 7'b0000000 if BLANK_TENS else 7'b0111111,
//   sync/edge flops 0. Reset mid-count wins over every other input in that cycle.
//  Inputs: run_btn/clr_btn pass through a 2-flop synchroniser, then an edge register; a
//   rising edge gives a one-cycle internal strobe 3 clk after the raw rise.
//   Holding a button high has no further effect.
//  Prescaler: counts 0..DIV-1 only while running=1; tick = (prescaler==DIV-1 && running).
//   On tick the prescaler returns to 0. While paused it holds its value.
//  Count on tick: up: 0..18 -> +1, 19 -> 0 with wrap_pulse; down: 1..19 -> -1, 0 -> 19 with
//   wrap_pulse. Stored as ones[3:0] (0..9) and tens (0..1); count_val = tens*10 + ones.
//  clr strobe: count 0, prescaler 0, wrap_pulse 0 in the same cycle. clr wins over a
//   coincident tick. running is unchanged by clr.
//  run strobe: running <= ~running. If run and clr strobe in the same cycle, both take effect.
//  Pause: the tick cannot fire while running=0, so the count freezes. Resume continues from
//   the held prescaler value, so no partial period is lost.
//  Outputs: count_val, running and wrap_pulse are registered with the state update.
//   disp0/disp1 are registered encodings of the new count, one clk after count_val changes.
//  Encoding 0..9: 3F 06 5B 4F 66 6D 7D 07 7F 6F (hex, 7-bit).
//   Illegal ones >9 cannot occur; the encoder maps it to 7'b0.
// STRUCTURE
//  Shared package counter_pkg: SEG_BLANK and SEG_DIGIT[0:9] constants, segment bit-order
//   localparams, MAX_COUNT = 19. The downstream display stage imports the same package.
//  One sub-module seg7_encode (4-bit in -> 7-bit out, combinational), instantiated twice.
//  The synchroniser/edge detect stays inline (two instances of the same always block).
// TESTING (bench: CLK_HZ=10, TICK_HZ=1 -> DIV=10)
//  1 rst_n=0 for 2 clk -> count_val=0, disp0=7'h3F, disp1=7'h00, running=0, wrap_pulse=0.
//  2 run_btn pulse, up_dn=1 -> running=1 after 3 clk; count_val=1 after 10 more clk;
//    disp0=7'h06 one clk after that.
//  3 Run up from 18 -> 19 (disp1=7'h06, disp0=7'h6F), then 0 with wrap_pulse=1 for 1 clk,
//    disp1=7'h00.
//  4 up_dn=0 from 0 -> 19 with wrap_pulse=1; keep counting down: 19->18->...->10->9,
//    tens blanks at 9.
//  5 Pause at prescaler=6 for 50 clk -> count held; after resume, next tick comes 4 clk later.
//  6 clr strobe coincident with tick -> count_val=0, no wrap_pulse. run and clr raised together
//    -> running toggles and count=0. rst_n low mid-count -> full reset state next edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared display constants: segment bit order, digit patterns and the counter ceiling.
// The downstream scan/multiplex stage imports this package as well.
package counter_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_G = 6;
  localparam int SEG_W = SEG_G - SEG_A + 1;

  localparam logic [SEG_W-1:0] SEG_BLANK = '0;

  // Patterns for 0..9, {g,f,e,d,c,b,a}, active-high
  localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam int         MAX_COUNT = 19;
  localparam logic [3:0] MAX_ONES  = 4'(MAX_COUNT % 10);
  localparam logic       MAX_TENS  = 1'(MAX_COUNT / 10);

endpackage

// File: rtl/bcd_counter_0_19_seg7.sv
// BCD digit to 7-segment pattern; anything above 9 comes out blank.
module seg7_encode
  import counter_pkg::*;
(
  input  logic [3:0]       digit,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_DIGIT[0];
      4'd1:    seg = SEG_DIGIT[1];
      4'd2:    seg = SEG_DIGIT[2];
      4'd3:    seg = SEG_DIGIT[3];
      4'd4:    seg = SEG_DIGIT[4];
      4'd5:    seg = SEG_DIGIT[5];
      4'd6:    seg = SEG_DIGIT[6];
      4'd7:    seg = SEG_DIGIT[7];
      4'd8:    seg = SEG_DIGIT[8];
      4'd9:    seg = SEG_DIGIT[9];
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_counter_0_19.sv
// Seconds-style 0..19 BCD counter with push-button run/clear and registered 7-segment outputs.
module bcd_counter_0_19
  import counter_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1,
  parameter int BLANK_TENS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_btn,
  input  logic             clr_btn,
  input  logic             up_dn,
  output logic [SEG_W-1:0] disp0,
  output logic [SEG_W-1:0] disp1,
  output logic [4:0]       count_val,
  output logic             running,
  output logic             wrap_pulse
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

  generate
    if (DIV < 2) begin : g_div_check
      $error("bcd_counter_0_19: CLK_HZ/TICK_HZ must be at least 2");
    end
  endgenerate

  logic          run_s1, run_s2, run_q;
  logic          clr_s1, clr_s2, clr_q;
  logic          run_stb, clr_stb;
  logic [PW-1:0] presc;
  logic          tick;
  logic [3:0]    ones, ones_n;
  logic          tens, tens_n;
  logic          wrap_n;
  logic [SEG_W-1:0] seg_ones, seg_tens;

  // Raw button levels: two synchroniser flops, then one more flop for the rising-edge strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_s1 <= 1'b0;
      run_s2 <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      run_s1 <= run_btn;
      run_s2 <= run_s1;
      run_q  <= run_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_s1 <= 1'b0;
      clr_s2 <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      clr_s1 <= clr_btn;
      clr_s2 <= clr_s1;
      clr_q  <= clr_s2;
    end
  end

  assign run_stb = run_s2 & ~run_q;
  assign clr_stb = clr_s2 & ~clr_q;
  assign tick    = running && (presc == PW'(DIV - 1));

  always_comb begin
    ones_n = ones;
    tens_n = tens;
    wrap_n = 1'b0;
    if (clr_stb) begin
      ones_n = 4'd0;
      tens_n = 1'b0;
    end else if (tick) begin
      if (up_dn) begin
        if (tens == MAX_TENS && ones == MAX_ONES) begin
          ones_n = 4'd0;
          tens_n = 1'b0;
          wrap_n = 1'b1;
        end else if (ones == 4'd9) begin
          ones_n = 4'd0;
          tens_n = 1'b1;
        end else begin
          ones_n = ones + 4'd1;
        end
      end else begin
        if (!tens && ones == 4'd0) begin
          ones_n = MAX_ONES;
          tens_n = MAX_TENS;
          wrap_n = 1'b1;
        end else if (ones == 4'd0) begin
          ones_n = 4'd9;
          tens_n = 1'b0;
        end else begin
          ones_n = ones - 4'd1;
        end
      end
    end
  end

  // A paused prescaler holds its phase so resuming loses no partial period
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc      <= '0;
      running    <= 1'b0;
      ones       <= 4'd0;
      tens       <= 1'b0;
      count_val  <= 5'd0;
      wrap_pulse <= 1'b0;
    end else begin
      if (clr_stb || tick) begin
        presc <= '0;
      end else if (running) begin
        presc <= presc + PW'(1);
      end
      running    <= running ^ run_stb;
      ones       <= ones_n;
      tens       <= tens_n;
      count_val  <= tens_n ? (5'd10 + {1'b0, ones_n}) : {1'b0, ones_n};
      wrap_pulse <= wrap_n;
    end
  end

  seg7_encode u_enc_ones (.digit(ones),          .seg(seg_ones));
  seg7_encode u_enc_tens (.digit({3'b000, tens}), .seg(seg_tens));

  // Displays trail count_val by one clock since they encode the already-registered digits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp0 <= SEG_DIGIT[0];
      disp1 <= (BLANK_TENS != 0) ? SEG_BLANK : SEG_DIGIT[0];
    end else begin
      disp0 <= seg_ones;
      disp1 <= ((BLANK_TENS != 0) && !tens) ? SEG_BLANK : seg_tens;
    end
  end

endmodule

// File: tb/tb_bcd_counter_0_19.sv
// Scoreboard bench for bcd_counter_0_19 with DIV=10: directed timing checks plus a monitor
// that pops the expected value for every change of count_val.
module tb_bcd_counter_0_19;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run_btn;
  logic       clr_btn;
  logic       up_dn;
  logic [6:0] disp0;
  logic [6:0] disp1;
  logic [4:0] count_val;
  logic       running;
  logic       wrap_pulse;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         count;
    bit         wrap;
    logic [6:0] d0;
    logic [6:0] d1;
  } exp_t;

  exp_t exp_q[$];
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  bit mon_en = 1'b0;

  bcd_counter_0_19 #(.CLK_HZ(10), .TICK_HZ(1), .BLANK_TENS(1)) dut (
    .clk(clk), .rst_n(rst_n), .run_btn(run_btn), .clr_btn(clr_btn), .up_dn(up_dn),
    .disp0(disp0), .disp1(disp1), .count_val(count_val), .running(running),
    .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void push_exp(input int c, input bit w);
    exp_t e;
    e.count = c;
    e.wrap  = w;
    e.d0    = seg_tab[c % 10];
    e.d1    = (c >= 10) ? 7'h06 : 7'h00;
    exp_q.push_back(e);
  endfunction

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input int target, input int budget, input string name);
    int n = 0;
    while (count_val != 5'(target) && n < budget) begin
      tick_n(1);
      n++;
    end
    check_output(name, int'(count_val), target);
  endtask

  task automatic apply_stimulus();
    // Reset state
    rst_n = 1'b0; run_btn = 1'b0; clr_btn = 1'b0; up_dn = 1'b1;
    tick_n(2);
    check_output("rst_count", int'(count_val), 0);
    check_output("rst_disp0", int'(disp0), 'h3F);
    check_output("rst_disp1", int'(disp1), 'h00);
    check_output("rst_running", int'(running), 0);
    check_output("rst_wrap", int'(wrap_pulse), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick_n(2);

    // Start: running three clocks after the raw rise, first tick ten clocks later
    push_exp(1, 0);
    run_btn = 1'b1;
    tick_n(2);
    check_output("run_latency_early", int'(running), 0);
    tick_n(1);
    check_output("run_latency", int'(running), 1);
    tick_n(2);
    run_btn = 1'b0;
    tick_n(7);
    check_output("first_tick_early", int'(count_val), 0);
    tick_n(1);
    check_output("first_tick", int'(count_val), 1);

    // Up through 19 and wrap to 0
    for (int c = 2; c <= 19; c++) push_exp(c, 0);
    push_exp(0, 1);
    wait_count(0, 250, "up_wrap_reached");

    // Down: wrap to 19, then on to 9
    up_dn = 1'b0;
    push_exp(19, 1);
    for (int c = 18; c >= 9; c--) push_exp(c, 0);
    wait_count(9, 150, "down_reached_9");

    // Pause with the prescaler at 6, then resume: next tick four clocks after running returns
    tick_n(3);
    run_btn = 1'b1;
    tick_n(3);
    check_output("pause_running", int'(running), 0);
    tick_n(50);
    check_output("pause_count_held", int'(count_val), 9);
    check_output("pause_still_off", int'(running), 0);
    run_btn = 1'b0;
    tick_n(3);
    push_exp(8, 0);
    run_btn = 1'b1;
    tick_n(3);
    check_output("resume_running", int'(running), 1);
    tick_n(3);
    check_output("resume_tick_early", int'(count_val), 9);
    tick_n(1);
    check_output("resume_tick", int'(count_val), 8);
    run_btn = 1'b0;

    // Clear strobe lands on the same edge as the next tick
    tick_n(7);
    push_exp(0, 0);
    clr_btn = 1'b1;
    tick_n(3);
    check_output("clr_on_tick_count", int'(count_val), 0);
    check_output("clr_on_tick_wrap", int'(wrap_pulse), 0);
    clr_btn = 1'b0;
    up_dn   = 1'b1;
    push_exp(1, 0);
    tick_n(10);
    check_output("after_clr_tick", int'(count_val), 1);

    // Run and clear together
    tick_n(3);
    push_exp(0, 0);
    run_btn = 1'b1;
    clr_btn = 1'b1;
    tick_n(3);
    check_output("run_clr_running", int'(running), 0);
    check_output("run_clr_count", int'(count_val), 0);
    run_btn = 1'b0;
    clr_btn = 1'b0;
    tick_n(30);
    check_output("run_clr_frozen", int'(count_val), 0);

    // Resume after clear: prescaler restarted from 0, so a full ten clocks to the tick
    push_exp(1, 0);
    run_btn = 1'b1;
    tick_n(3);
    check_output("resume2_running", int'(running), 1);
    tick_n(9);
    check_output("presc_cleared_early", int'(count_val), 0);
    tick_n(1);
    check_output("presc_cleared_tick", int'(count_val), 1);
    run_btn = 1'b0;

    // Reset in the middle of a period
    tick_n(4);
    push_exp(0, 0);
    rst_n = 1'b0;
    tick_n(1);
    check_output("midrst_count", int'(count_val), 0);
    check_output("midrst_running", int'(running), 0);
    check_output("midrst_wrap", int'(wrap_pulse), 0);
    check_output("midrst_disp0", int'(disp0), 'h3F);
    check_output("midrst_disp1", int'(disp1), 'h00);
    tick_n(2);
    rst_n = 1'b1;
    tick_n(12);
    check_output("idle_after_rst", int'(count_val), 0);
    check_output("scoreboard_empty", exp_q.size(), 0);
  endtask

  // Monitor: every count_val change pops one expected entry; displays are checked a clock later
  exp_t       pend_exp;
  bit         pend = 1'b0;
  logic [4:0] prev_count;

  always @(negedge clk) begin
    exp_t e;
    if (!mon_en) begin
      prev_count = count_val;
    end else begin
      if (pend) begin
        check_output("mon_disp0", int'(disp0), int'(pend_exp.d0));
        check_output("mon_disp1", int'(disp1), int'(pend_exp.d1));
        pend = 1'b0;
      end
      if (count_val != prev_count) begin
        if (exp_q.size() == 0) begin
          check_output("mon_unexpected_change", int'(count_val), int'(prev_count));
        end else begin
          e = exp_q.pop_front();
          check_output("mon_count", int'(count_val), e.count);
          check_output("mon_wrap", int'(wrap_pulse), int'(e.wrap));
          pend_exp = e;
          pend     = 1'b1;
        end
      end else if (wrap_pulse) begin
        check_output("mon_spurious_wrap", int'(wrap_pulse), 0);
      end
      prev_count = count_val;
    end
  end

  initial begin
    apply_stimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
